// File: rtl/f8_mem_responder.sv
// F8 memory-side ROMC responder: PC0/PC1/DC0 address registers, windowed bus reads/writes.
// Optional DC1 register and ROMC 1D swap when F8_DC1_EN is defined.
module f8_mem_responder #(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter logic [15:0] ADDR_MASK = 16'hF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  romc,
  input  logic        romc_vld,
  input  logic        write,
  input  logic [7:0]  db_in,
  output logic [7:0]  db_out,
  output logic        db_t,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_RDWAIT,
    S_DRIVE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_romc;
  logic [15:0] r_pc0;
  logic [15:0] r_pc1;
  logic [15:0] r_dc0;
`ifdef F8_DC1_EN
  logic [15:0] r_dc1;
`endif
  logic [7:0]  r_db_out;
  logic        r_db_t;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic        r_mem_we;
  logic [7:0]  r_mem_wdata;
  logic        r_err;

  logic        w_memrd;
  logic        w_reg_hit;
  logic [7:0]  w_reg_val;
  logic [15:0] w_rd_addr;
  logic [15:0] w_sx;

  function automatic logic f_in_win(input logic [15:0] a);
    return (a & ADDR_MASK) == ADDR_BASE;
  endfunction

  assign w_rd_addr = (r_romc == 5'h02) ? r_dc0 : r_pc0;
  assign w_sx      = {{8{db_in[7]}}, db_in};

  always_comb begin
    w_memrd = 1'b0;
    case (r_romc)
      5'h00, 5'h01, 5'h02, 5'h03,
      5'h0C, 5'h0E, 5'h11: w_memrd = 1'b1;
      default:             w_memrd = 1'b0;
    endcase
  end

  always_comb begin
    w_reg_hit = 1'b1;
    w_reg_val = 8'hFF;
    case (r_romc)
      5'h06:   w_reg_val = r_dc0[15:8];
      5'h07:   w_reg_val = r_pc1[15:8];
      5'h09:   w_reg_val = r_dc0[7:0];
      5'h0B:   w_reg_val = r_pc1[7:0];
      5'h1E:   w_reg_val = r_pc0[7:0];
      5'h1F:   w_reg_val = r_pc0[15:8];
      default: w_reg_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_romc      <= 5'h00;
      r_pc0       <= 16'h0000;
      r_pc1       <= 16'h0000;
      r_dc0       <= 16'h0000;
`ifdef F8_DC1_EN
      r_dc1       <= 16'h0000;
`endif
      r_db_out    <= 8'hFF;
      r_db_t      <= 1'b1;
      r_mem_addr  <= 16'h0000;
      r_mem_rd    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_mem_we <= 1'b0;
      if (write && r_state != S_IDLE) begin
        // End of machine cycle: commit the latched code's update
        r_db_t  <= 1'b1;
        r_state <= S_IDLE;
        if (r_state == S_RDWAIT) r_err <= 1'b1;
        case (r_romc)
          5'h00, 5'h03: r_pc0 <= r_pc0 + 16'h0001;
          5'h01: r_pc0 <= r_pc0 + w_sx;
          5'h02: r_dc0 <= r_dc0 + 16'h0001;
          5'h04: r_pc0 <= r_pc1;
          5'h05: begin
            if (f_in_win(r_dc0)) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_dc0;
              r_mem_wdata <= db_in;
            end
            r_dc0 <= r_dc0 + 16'h0001;
          end
          5'h08: begin
            r_pc1 <= r_pc0;
            r_pc0 <= {db_in, db_in};
          end
          5'h0A: r_dc0 <= r_dc0 + w_sx;
          5'h0C: r_pc0[7:0] <= db_in;
          5'h0D: r_pc1 <= r_pc0 + 16'h0001;
          5'h0E: r_dc0[7:0] <= db_in;
          5'h11: r_dc0[15:8] <= db_in;
          5'h12: begin
            r_pc1       <= r_pc0;
            r_pc0[7:0]  <= db_in;
          end
          5'h14: r_pc0[15:8] <= db_in;
          5'h15: r_pc1[15:8] <= db_in;
          5'h16: r_dc0[15:8] <= db_in;
          5'h17: r_pc0[7:0] <= db_in;
          5'h18: r_pc1[7:0] <= db_in;
          5'h19: r_dc0[7:0] <= db_in;
`ifdef F8_DC1_EN
          5'h1D: begin
            r_dc0 <= r_dc1;
            r_dc1 <= r_dc0;
          end
`endif
          default: ;
        endcase
      end else if (romc_vld &&
                   (r_state == S_DECODE || r_state == S_RDWAIT)) begin
        r_err  <= 1'b1;
        r_db_t <= 1'b1;
      end else begin
        case (r_state)
          S_DECODE: begin
            r_state <= S_DRIVE;
            if (w_memrd) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_rd_addr;
              if (f_in_win(w_rd_addr)) r_state <= S_RDWAIT;
            end else if (w_reg_hit) begin
              r_db_out <= w_reg_val;
              r_db_t   <= 1'b0;
            end
          end
          S_RDWAIT: begin
            if (mem_ack) begin
              r_db_out <= mem_rdata;
              r_db_t   <= 1'b0;
              r_state  <= S_DRIVE;
            end
          end
          default: ;
        endcase
      end
      // A new code is accepted after any same-edge update
      if (romc_vld) begin
        r_romc  <= romc;
        r_state <= S_DECODE;
        r_db_t  <= 1'b1;
      end
    end
  end

  assign db_out    = r_db_out;
  assign db_t      = r_db_t;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_f8_mem_responder.sv
// Scoreboard bench for f8_mem_responder: directed ROMC cycles, queued
// expectations popped by a negedge monitor on mem_rd, mem_we and write.
module tb_f8_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  romc;
  logic        romc_vld;
  logic        write;
  logic [7:0]  db_in;
  logic [7:0]  db_out;
  logic        db_t;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        err;

  int checks = 0;
  int errors = 0;
  int ack_dly = 2;
  logic [7:0] rd_val = 8'h00;

  typedef struct packed {
    logic       drv;
    logic [7:0] val;
  } bx_t;

  bx_t         dbq[$];
  logic [15:0] rdq[$];
  logic [23:0] weq[$];

  f8_mem_responder dut (
    .clk(clk), .rst(rst), .romc(romc), .romc_vld(romc_vld),
    .write(write), .db_in(db_in), .db_out(db_out), .db_t(db_t),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic [4:0] c, input logic [7:0] d,
                     input logic drv, input logic [7:0] v,
                     input int wr_at);
    dbq.push_back({drv, v});
    romc = c;
    romc_vld = 1'b1;
    tick();
    romc_vld = 1'b0;
    repeat (wr_at - 1) tick();
    db_in = d;
    write = 1'b1;
    tick();
    write = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [4:0] c, input logic [7:0] v);
    cyc(c, 8'h00, 1'b1, v, 6);
  endtask

  task automatic set(input logic [4:0] c, input logic [7:0] d);
    cyc(c, d, 1'b0, 8'h00, 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Memory model: ack ack_dly clocks after a read strobe
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      tick();
      mem_ack = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = rd_val;
        end
      end
      if (mem_rd && ack_dly > 0) cnt = ack_dly;
    end
  end

  initial begin
    bx_t e;
    logic [23:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_rd) begin
          if (rdq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_rd: unexpected read at %h", mem_addr);
          end else chk("mem_rd_addr", {16'h0, mem_addr}, {16'h0, rdq.pop_front()});
        end
        if (mem_we) begin
          if (weq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_we: unexpected write %h=%h", mem_addr, mem_wdata);
          end else begin
            w = weq.pop_front();
            chk("mem_we_addr", {16'h0, mem_addr}, {16'h0, w[23:8]});
            chk("mem_we_data", {24'h0, mem_wdata}, {24'h0, w[7:0]});
          end
        end
        if (write) begin
          if (dbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus: write with no expectation queued");
          end else begin
            e = dbq.pop_front();
            chk("db_t", {31'h0, db_t}, {31'h0, ~e.drv});
            if (e.drv) chk("db_out", {24'h0, db_out}, {24'h0, e.val});
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    romc = 5'h00;
    romc_vld = 1'b0;
    write = 1'b0;
    db_in = 8'h00;
    tick();
    tick();
    chk("rst_db_t", {31'h0, db_t}, 32'h1);
    chk("rst_db_out", {24'h0, db_out}, 32'hFF);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    rst = 1'b0;
    tick();

    // Memory read and PC0 increment
    rd_val = 8'h2A;
    rdq.push_back(16'h0000);
    cyc(5'h00, 8'h00, 1'b1, 8'h2A, 6);
    rd(5'h1E, 8'h01);
    rd(5'h1F, 8'h00);

    // Relative branch and wrap
    set(5'h14, 8'h00);
    set(5'h17, 8'h10);
    rd_val = 8'h77;
    rdq.push_back(16'h0010);
    cyc(5'h01, 8'hFE, 1'b1, 8'h77, 6);
    rd(5'h1E, 8'h0E);
    rd(5'h1F, 8'h00);
    set(5'h14, 8'hFF);
    set(5'h17, 8'hFF);
    rdq.push_back(16'hFFFF);
    cyc(5'h00, 8'h00, 1'b0, 8'h00, 6);
    rd(5'h1E, 8'h00);
    rd(5'h1F, 8'h00);
    chk("err_after_miss", {31'h0, err}, 32'h0);

    // Store at window edge
    set(5'h16, 8'h07);
    set(5'h19, 8'hFF);
    weq.push_back({16'h07FF, 8'h5C});
    cyc(5'h05, 8'h5C, 1'b0, 8'h00, 6);
    rd(5'h09, 8'h00);
    rd(5'h06, 8'h08);
    cyc(5'h05, 8'h33, 1'b0, 8'h00, 6);
    rd(5'h09, 8'h01);
    rd(5'h06, 8'h08);
    rd_val = 8'hC3;
    rdq.push_back(16'h0801);
    cyc(5'h02, 8'h00, 1'b0, 8'h00, 6);
    rd(5'h09, 8'h02);

    // Early write during read wait
    set(5'h14, 8'h01);
    set(5'h17, 8'h00);
    ack_dly = 5;
    rd_val = 8'h99;
    rdq.push_back(16'h0100);
    cyc(5'h00, 8'h00, 1'b0, 8'h00, 2);
    repeat (6) tick();
    chk("late_ack_db_t", {31'h0, db_t}, 32'h1);
    chk("late_err", {31'h0, err}, 32'h1);
    ack_dly = 2;
    rd(5'h1E, 8'h01);
    rd(5'h1F, 8'h01);
    do_reset();
    chk("err_cleared", {31'h0, err}, 32'h0);
    rd(5'h1E, 8'h00);

    // PC1 transfers
    set(5'h14, 8'h12);
    set(5'h17, 8'h34);
    set(5'h08, 8'h00);
    rd(5'h0B, 8'h34);
    rd(5'h07, 8'h12);
    rd(5'h1E, 8'h00);
    rd(5'h1F, 8'h00);
    set(5'h0D, 8'h00);
    rd(5'h0B, 8'h01);
    set(5'h04, 8'h00);
    rd(5'h1E, 8'h01);

    // Write and new code on the same edge
    dbq.push_back({1'b0, 8'h00});
    romc = 5'h17;
    romc_vld = 1'b1;
    tick();
    romc_vld = 1'b0;
    tick();
    tick();
    db_in = 8'h55;
    write = 1'b1;
    romc = 5'h1E;
    romc_vld = 1'b1;
    dbq.push_back({1'b1, 8'h55});
    tick();
    write = 1'b0;
    romc_vld = 1'b0;
    repeat (3) tick();
    write = 1'b1;
    tick();
    write = 1'b0;
    tick();

    // DC0/DC1 swap
    set(5'h16, 8'h22);
    set(5'h19, 8'h22);
    set(5'h1D, 8'h00);
    set(5'h16, 8'h11);
    set(5'h19, 8'h11);
    set(5'h1D, 8'h00);
`ifdef F8_DC1_EN
    rd(5'h09, 8'h22);
    rd(5'h06, 8'h22);
    set(5'h1D, 8'h00);
    rd(5'h09, 8'h11);
`else
    rd(5'h09, 8'h11);
    rd(5'h06, 8'h11);
    set(5'h1D, 8'h00);
    rd(5'h09, 8'h11);
`endif
    chk("err_end", {31'h0, err}, 32'h0);

    repeat (4) tick();
    chk("rdq_drained", rdq.size(), 32'h0);
    chk("weq_drained", weq.size(), 32'h0);
    chk("dbq_drained", dbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f8_mem_responder.md
F8_MEM_RESPONDER -- requirements
Module: f8_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 16'h0000, base of the memory window this device answers.
REQ-002 SHALL have parameter ADDR_MASK, default 16'hF800, mask that selects the window compare bits.
REQ-003 SHALL have port clk  in  1  system clock, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port romc  in  5  ROMC code of the current machine cycle.
REQ-006 SHALL have port romc_vld  in  1  one-clk pulse; romc is valid and a new machine cycle starts.
REQ-007 SHALL have port write  in  1  one-clk pulse; the machine cycle ends and db_in is valid.
REQ-008 SHALL have port db_in  in  8  data bus sampled value.
REQ-009 SHALL have port db_out  out  8  data bus drive value.
REQ-010 SHALL have port db_t  out  1  1 = bus released, 0 = drive db_out.
REQ-011 SHALL have ports mem_addr (out 16), mem_rd (out 1, read pulse), mem_we (out 1, write pulse), mem_wdata (out 8), mem_rdata (in 8), mem_ack (in 1, read data valid pulse).
REQ-012 SHALL have port err  out  1  sticky fault: read data late or handshake violation.

Function
REQ-013 SHALL hold 16-bit registers PC0, PC1, DC0 (plus DC1, see Configuration); all arithmetic is mod 2^16.
REQ-014 On romc_vld, SHALL latch romc; for memory-read codes (00,01,02,03,0C,0E,11), SHALL assert mem_rd for one clk on the next edge, with mem_addr = PC0 (DC0 for 02).
REQ-015 On a read whose address is in the window ((addr & ADDR_MASK) == ADDR_BASE), SHALL register mem_rdata on mem_ack, then drive db_out with it and set db_t = 0 from the next clk until write.
REQ-016 For register-read codes, SHALL drive db_t = 0 from the clk after romc_vld: 06 DC0[15:8], 07 PC1[15:8], 09 DC0[7:0], 0B PC1[7:0], 1E PC0[7:0], 1F PC0[15:8]; the window check does not apply.
REQ-017 On write, SHALL set db_t = 1 and apply these updates, using db_in where a bus value is needed:
  - 00, 03: PC0 += 1.
  - 01: PC0 += sign-extended db_in.
  - 02: DC0 += 1.
  - 04: PC0 = PC1.
  - 05: mem_we pulse, mem_addr = DC0, mem_wdata = db_in if in window; then DC0 += 1.
  - 08: PC1 = PC0; PC0 = {db_in, db_in}.
  - 0A: DC0 += sign-extended db_in.
  - 0C: PC0[7:0] = db_in.
  - 0D: PC1 = PC0 + 1.
  - 0E: DC0[7:0] = db_in.
  - 11: DC0[15:8] = db_in.
  - 12: PC1 = PC0; PC0[7:0] = db_in.
  - 14: PC0[15:8] = db_in.
  - 15: PC1[15:8] = db_in.
  - 16: DC0[15:8] = db_in.
  - 17: PC0[7:0] = db_in.
  - 18: PC1[7:0] = db_in.
  - 19: DC0[7:0] = db_in.
  - 1D: see REQ-024.
  - All other codes: no change, bus never driven.
REQ-018 SHALL implement the cycle FSM IDLE -> (romc_vld) DECODE -> RDWAIT (memory-read codes) or DRIVE -> (write) IDLE.
REQ-019 If write arrives in RDWAIT, SHALL set err and still perform the REQ-017 update; a later mem_ack for that cycle is ignored.
REQ-020 If romc_vld and write occur on the same edge, SHALL complete the old cycle's update first, then accept the new code in that same edge.
REQ-021 If romc_vld arrives outside IDLE/DRIVE without write, SHALL set err, abandon the cycle without any update, and start the new one.
REQ-022 A mem_ack outside RDWAIT SHALL be ignored.

Reset
REQ-023 While rst is high, SHALL clear PC0, PC1, DC0, DC1 and err, and set db_t = 1, db_out = 8'hFF, mem_rd = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, FSM = IDLE; a cycle in flight is aborted and its pending ack ignored.

Configuration
REQ-024 With macro F8_DC1_EN defined, SHALL include the DC1 register and ROMC 1D SHALL swap DC0 and DC1 on write; without it, DC1 SHALL be absent and 1D SHALL be a no-op.

Verification
REQ-025 Reset, then ROMC 00 with mem_rdata = 8'h2A, ack 2 clks after mem_rd -> mem_addr = 0000, db_out = 2A, db_t = 0, PC0 = 0001 after write.
REQ-026 PC0 = 0010, ROMC 01, db_in = 8'hFE -> PC0 = 000E; with PC0 = FFFF and ROMC 00 -> PC0 = 0000.
REQ-027 DC0 = 07FF, ROMC 05, db_in = 8'h5C -> one mem_we at 07FF with data 5C, DC0 = 0800; repeated with DC0 = 0800 -> no mem_we, DC0 = 0801.
REQ-028 ROMC 00 with write before mem_ack -> err = 1, PC0 still incremented, the late ack does not drive the bus; rst clears err.
REQ-029 PC0 = 1234, ROMC 08, db_in = 00 -> PC1 = 1234, PC0 = 0000; ROMC 1F -> db_out = 00.
REQ-030 With F8_DC1_EN, DC0 = 1111, DC1 = 2222, ROMC 1D -> DC0 = 2222, DC1 = 1111; without it, DC0 stays 1111.
